// File: rtl/slowmem_arbiter.sv
// slowmem_arbiter: shares one slow memory port between two instruction-cache
// read ports and one data port. A single transaction is in flight at a time:
// IDLE grants, STROBE pulses mem_strobe for one cycle, and WAIT waits for mem_mfc
// on reads. Data requests always win. Optional macro ARB_ROUND_ROBIN_EN makes
// instruction ports alternate on a tie. Without it, port 0 beats port 1.
// All outputs come straight from flops.
module slowmem_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        ireq0,
   input  logic        ireq1,
   input  logic [15:0] iaddr0,
   input  logic [15:0] iaddr1,
   input  logic        dreq,
   input  logic        drnotw,
   input  logic [15:0] daddr,
   input  logic [15:0] dwdata,
   output logic        idone0,
   output logic        idone1,
   output logic        ddone,
   output logic [15:0] rdata,
   output logic        busy,
   output logic        mem_strobe,
   output logic        mem_rnotw,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_mfc,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      WAIT   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_I0 = 2'd0,
      OWN_I1 = 2'd1,
      OWN_D  = 2'd2
   } owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   logic        mem_strobe_q, mem_strobe_d;
   logic        mem_rnotw_q, mem_rnotw_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic        idone0_q, idone0_d;
   logic        idone1_q, idone1_d;
   logic        ddone_q, ddone_d;
   logic [15:0] rdata_q, rdata_d;
   logic        busy_q, busy_d;
   logic        pick_i1;
`ifdef ARB_ROUND_ROBIN_EN
   logic        rr_last_q, rr_last_d;
`endif

   // Decide which instruction port wins if an instruction grant happens now
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      if (ireq0 && ireq1) begin
         pick_i1 = ~rr_last_q;
      end else begin
         pick_i1 = ireq1;
      end
`else
      if (ireq0) begin
         pick_i1 = 1'b0;
      end else begin
         pick_i1 = ireq1;
      end
`endif
   end

   // Next-state and registered-output computation for the grant/strobe/wait sequence
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      mem_strobe_d = 1'b0;
      mem_rnotw_d  = mem_rnotw_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      idone0_d     = 1'b0;
      idone1_d     = 1'b0;
      ddone_d      = 1'b0;
      rdata_d      = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_d    = rr_last_q;
`endif
      case (state_q)
         IDLE: begin
            if (dreq) begin
               owner_d      = OWN_D;
               mem_addr_d   = daddr;
               mem_rnotw_d  = drnotw;
               mem_wdata_d  = dwdata;
               mem_strobe_d = 1'b1;
               state_d      = STROBE;
            end else if (ireq0 || ireq1) begin
               owner_d      = pick_i1 ? OWN_I1 : OWN_I0;
               mem_addr_d   = pick_i1 ? iaddr1 : iaddr0;
               mem_rnotw_d  = 1'b1;
               mem_strobe_d = 1'b1;
               state_d      = STROBE;
`ifdef ARB_ROUND_ROBIN_EN
               rr_last_d    = pick_i1;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         STROBE: begin
            if (mem_rnotw_q) begin
               state_d = WAIT;
            end else begin
               // Writes complete as soon as the strobe has been presented
               idone0_d = (owner_q == OWN_I0);
               idone1_d = (owner_q == OWN_I1);
               ddone_d  = (owner_q == OWN_D);
               state_d  = IDLE;
            end
         end
         WAIT: begin
            if (mem_mfc) begin
               rdata_d  = mem_rdata;
               idone0_d = (owner_q == OWN_I0);
               idone1_d = (owner_q == OWN_I1);
               ddone_d  = (owner_q == OWN_D);
               state_d  = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= OWN_I0;
         mem_strobe_q <= 1'b0;
         mem_rnotw_q  <= 1'b1;
         mem_addr_q   <= 16'h0000;
         mem_wdata_q  <= 16'h0000;
         idone0_q     <= 1'b0;
         idone1_q     <= 1'b0;
         ddone_q      <= 1'b0;
         rdata_q      <= 16'h0000;
         busy_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_last_q    <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         mem_strobe_q <= mem_strobe_d;
         mem_rnotw_q  <= mem_rnotw_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         idone0_q     <= idone0_d;
         idone1_q     <= idone1_d;
         ddone_q      <= ddone_d;
         rdata_q      <= rdata_d;
         busy_q       <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
         rr_last_q    <= rr_last_d;
`endif
      end
   end

   assign idone0     = idone0_q;
   assign idone1     = idone1_q;
   assign ddone      = ddone_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign mem_strobe = mem_strobe_q;
   assign mem_rnotw  = mem_rnotw_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_slowmem_arbiter.sv
// Testbench for slowmem_arbiter: behavioural slow memory (MEMDELAY=4), a
// transaction-level reference model predicting the service order and data, and
// a scoreboard monitor checking every done pulse, strobe width and busy.
module tb_slowmem_arbiter;

   localparam int MEMDELAY = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq0, ireq1, dreq, drnotw;
   logic [15:0] iaddr0, iaddr1, daddr, dwdata;
   logic        idone0, idone1, ddone, busy;
   logic [15:0] rdata;
   logic        mem_strobe, mem_rnotw;
   logic [15:0] mem_addr, mem_wdata;
   logic        sm_mfc = 1'b0;
   logic [15:0] sm_rdata = 16'h0000;

   typedef struct {
      int          who;      // 0 = ireq0, 1 = ireq1, 2 = dreq
      bit          is_read;
      logic [15:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] sm_mem  [logic [15:0]];
   bit          rr_model = 1'b1;

   always #5 clk = ~clk;

   slowmem_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .ireq0      (ireq0),
      .ireq1      (ireq1),
      .iaddr0     (iaddr0),
      .iaddr1     (iaddr1),
      .dreq       (dreq),
      .drnotw     (drnotw),
      .daddr      (daddr),
      .dwdata     (dwdata),
      .idone0     (idone0),
      .idone1     (idone1),
      .ddone      (ddone),
      .rdata      (rdata),
      .busy       (busy),
      .mem_strobe (mem_strobe),
      .mem_rnotw  (mem_rnotw),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_mfc    (sm_mfc),
      .mem_rdata  (sm_rdata)
   );

   // Unwritten locations read as addr ^ 0x1224, so location 0x0010 holds 0x1234
   function automatic logic [15:0] dflt(input logic [15:0] a);
      return a ^ 16'h1224;
   endfunction

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [15:0] sm_rd(input logic [15:0] a);
      return sm_mem.exists(a) ? sm_mem[a] : dflt(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string name);
      check(name, {mem_strobe, mem_rnotw, mem_addr, mem_wdata, idone0, idone1, ddone, rdata, busy},
            {1'b0, 1'b1, 16'h0000, 16'h0000, 3'b000, 16'h0000, 1'b0});
   endtask

   // Slow memory: write on strobe; read raises mfc so it is sampled MEMDELAY edges after the strobe
   initial begin : slowmem
      int          cnt;
      logic [15:0] data;
      cnt  = 0;
      data = 16'h0000;
      forever begin
         @(posedge clk);
         if (sm_mfc) sm_mfc <= 1'b0;
         if (mem_strobe) begin
            if (!mem_rnotw) begin
               sm_mem[mem_addr] = mem_wdata;
            end else begin
               cnt  = MEMDELAY - 1;
               data = sm_rd(mem_addr);
            end
         end else if (cnt != 0) begin
            if (cnt == 1) begin
               sm_mfc   <= 1'b1;
               sm_rdata <= data;
            end
            cnt--;
         end
      end
   end

   // Scoreboard monitor: every done is popped and compared; strobe and busy checked each cycle
   initial begin : monitor
      int   cyc, strobe_cyc, ndone, who;
      bit   outstanding, strobe_prev, strobe_rd;
      exp_t e;
      cyc = 0; strobe_cyc = 0; outstanding = 1'b0; strobe_prev = 1'b0; strobe_rd = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            outstanding = 1'b0;
         end else begin
            if (mem_strobe) begin
               check("strobe_single_cycle", 64'(strobe_prev), 64'd0);
               check("strobe_no_overlap", 64'(outstanding && !strobe_prev), 64'd0);
               outstanding = 1'b1;
               strobe_cyc  = cyc;
               strobe_rd   = mem_rnotw;
            end
            ndone = int'(idone0) + int'(idone1) + int'(ddone);
            if (ndone != 0) begin
               check("single_done", 64'(ndone), 64'd1);
               who = ddone ? 2 : (idone1 ? 1 : 0);
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_done: got done for requester %0d, expected none", who);
               end else begin
                  e = sb_q.pop_front();
                  check("done_order", 64'(who), 64'(e.who));
                  check("direction", 64'(strobe_rd), 64'(e.is_read));
                  if (e.is_read) check("rdata", 64'(rdata), 64'(e.data));
                  check("latency", 64'(cyc - strobe_cyc), e.is_read ? 64'(MEMDELAY + 1) : 64'd1);
               end
               outstanding = 1'b0;
            end
            check("busy", 64'(busy), 64'(outstanding));
         end
         strobe_prev = mem_strobe;
      end
   end

   // Reference model: expected reply for one served requester, in service order
   task automatic push_exp(input int who, input bit d_rnw, input logic [15:0] da,
                           input logic [15:0] dw, input logic [15:0] a0, input logic [15:0] a1);
      exp_t e;
      e.who = who;
      if (who == 2) begin
         e.is_read = d_rnw;
         if (d_rnw) begin
            e.data = ref_rd(da);
         end else begin
            ref_mem[da] = dw;
            e.data      = dw;
         end
      end else begin
         e.is_read = 1'b1;
         e.data    = ref_rd(who == 0 ? a0 : a1);
         rr_model  = (who == 1);
      end
      sb_q.push_back(e);
   endtask

   // One round: the chosen requesters assert together, each drops after its own done
   task automatic do_round(input bit ud, input bit d_rnw, input logic [15:0] da, input logic [15:0] dw,
                           input bit u0, input logic [15:0] a0, input bit u1, input logic [15:0] a1);
      int order[$];
      bit pd, p0, p1;
      int guard;
      if (ud) order.push_back(2);
      if (u0 && u1) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (rr_model) begin order.push_back(0); order.push_back(1); end
         else begin order.push_back(1); order.push_back(0); end
`else
         order.push_back(0); order.push_back(1);
`endif
      end else if (u0) begin
         order.push_back(0);
      end else if (u1) begin
         order.push_back(1);
      end
      foreach (order[k]) push_exp(order[k], d_rnw, da, dw, a0, a1);
      @(negedge clk);
      dreq = ud; drnotw = d_rnw; daddr = da; dwdata = dw;
      ireq0 = u0; iaddr0 = a0; ireq1 = u1; iaddr1 = a1;
      pd = ud; p0 = u0; p1 = u1; guard = 0;
      while ((pd || p0 || p1) && guard < 200) begin
         @(negedge clk);
         guard++;
         if (ddone)  begin pd = 1'b0; dreq  = 1'b0; end
         if (idone0) begin p0 = 1'b0; ireq0 = 1'b0; end
         if (idone1) begin p1 = 1'b0; ireq1 = 1'b0; end
      end
      if (pd || p0 || p1) begin
         n_tests++;
         n_fail++;
         $display("FAIL round_timeout: pending d=%0d i0=%0d i1=%0d after %0d cycles, expected none", pd, p0, p1, guard);
         dreq = 1'b0; ireq0 = 1'b0; ireq1 = 1'b0;
      end
   endtask

   // Both instruction ports held high for four transactions
   task automatic held4(input logic [15:0] a0, input logic [15:0] a1);
      int cnt, guard, who;
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         who = rr_model ? 0 : 1;
`else
         who = 0;
`endif
         push_exp(who, 1'b1, 16'h0000, 16'h0000, a0, a1);
      end
      @(negedge clk);
      ireq0 = 1'b1; iaddr0 = a0; ireq1 = 1'b1; iaddr1 = a1;
      cnt = 0; guard = 0;
      while (cnt < 4 && guard < 400) begin
         @(negedge clk);
         guard++;
         if (idone0 || idone1) cnt++;
      end
      ireq0 = 1'b0; ireq1 = 1'b0;
      check("held4_done_count", 64'(cnt), 64'd4);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int          guard;
      logic [15:0] a0, a1, da, dw;
      bit          ud, u0, u1, rnw;
      reset = 1'b1;
      ireq0 = 1'b0; ireq1 = 1'b0; dreq = 1'b0; drnotw = 1'b1;
      iaddr0 = 16'h0000; iaddr1 = 16'h0000; daddr = 16'h0000; dwdata = 16'h0000;
      repeat (2) @(negedge clk);
      check_reset("reset_values");
      reset = 1'b0;

      // Contention straight after reset: data first, then port 0, then port 1
      do_round(1'b1, 1'b1, 16'h0030, 16'h0000, 1'b1, 16'h0040, 1'b1, 16'h0050);
      // Single read of preloaded 0x0010 (expects 0x1234)
      do_round(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000);
      // Write 0xBEEF to 0x0020 then read it back
      do_round(1'b1, 1'b0, 16'h0020, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000);
      do_round(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0020);
      // Fairness with both instruction ports held
      held4(16'h0010, 16'h0020);

      // Request dropped while the read is in WAIT
      push_exp(0, 1'b1, 16'h0000, 16'h0000, 16'h0012, 16'h0000);
      @(negedge clk);
      ireq0 = 1'b1; iaddr0 = 16'h0012;
      repeat (3) @(negedge clk);
      check("busy_in_wait", 64'(busy), 64'd1);
      ireq0 = 1'b0;
      guard = 0;
      while (!idone0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("dropped_req_done", 64'(idone0), 64'd1);
      @(negedge clk);
      check("dropped_req_idle", 64'(busy), 64'd0);
      repeat (8) @(negedge clk);

      // Reset two edges after a read grant; the late mfc must be ignored
      @(negedge clk);
      ireq0 = 1'b1; iaddr0 = 16'h0014;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      ireq0 = 1'b0;
      #1;
      check_reset("reset_mid_read");
      rr_model = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      do_round(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0016);

      // Randomized rounds over a small address pool so reads hit earlier writes
      for (int r = 0; r < 40; r++) begin
         ud  = 1'($urandom_range(0, 1));
         u0  = 1'($urandom_range(0, 1));
         u1  = 1'($urandom_range(0, 1));
         rnw = 1'($urandom_range(0, 1));
         if (!ud && !u0 && !u1) u1 = 1'b1;
         a0 = 16'h0010 + 16'($urandom_range(0, 7) * 2);
         a1 = 16'h0010 + 16'($urandom_range(0, 7) * 2);
         da = 16'h0010 + 16'($urandom_range(0, 7) * 2);
         dw = 16'($urandom);
         do_round(ud, rnw, da, dw, u0, a0, u1, a1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (10) @(negedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
